// File: rtl/rat_io_pkg.sv
// Shared types and constants for the registered 1-to-N demultiplexer.
package rat_io_pkg;

    // Width of the destination port address.
    localparam int unsigned PORT_ID_W = 8;

    // Address that maps to output port 0 unless overridden.
    localparam logic [PORT_ID_W-1:0] DEFAULT_BASE_ID = 8'h10;

    // Write handshake sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACK   = 2'd2
    } state_t;

endpackage : rat_io_pkg

// File: rtl/demux_1tn_reg_port_id_decode.sv
// Maps an 8-bit port address onto a one-hot port select plus a hit flag.
module port_id_decode
    import rat_io_pkg::*;
#(
    parameter int unsigned            PORTS   = 4,
    parameter logic [PORT_ID_W-1:0]   BASE_ID = DEFAULT_BASE_ID
) (
    input  logic [PORT_ID_W-1:0] id,
    output logic [PORTS-1:0]     onehot_c,
    output logic                 hit_c
);

    // One extra bit so the offset never wraps when BASE_ID sits near 255.
    localparam int unsigned OFF_W = PORT_ID_W + 1;

    logic [OFF_W-1:0] offset;

    // Unsigned range check followed by a one-hot expansion of the offset.
    always_comb begin
        onehot_c = '0;
        offset   = OFF_W'(id) - OFF_W'(BASE_ID);
        hit_c    = (id >= BASE_ID) && (offset < OFF_W'(PORTS));
        for (int unsigned k = 0; k < PORTS; k++) begin
            onehot_c[k] = hit_c && (offset == OFF_W'(k));
        end
    end

endmodule : port_id_decode

// File: rtl/demux_1tn_reg.sv
// Registered 1-to-N demultiplexer with a three-state write handshake.
// Optional readback port enabled by defining DEMUX_1TN_REG_READBACK_EN.
module demux_1tn_reg
    import rat_io_pkg::*;
#(
    parameter int unsigned            n       = 8,
    parameter int unsigned            PORTS   = 4,
    parameter logic [PORT_ID_W-1:0]   BASE_ID = DEFAULT_BASE_ID
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [PORT_ID_W-1:0]  port_id,
    input  logic [n-1:0]          d_in,
`ifdef DEMUX_1TN_REG_READBACK_EN
    input  logic [PORT_ID_W-1:0]  rb_id,
    output logic [n-1:0]          rb_data,
`endif
    output logic                  wr_ack,
    output logic                  busy,
    output logic [PORTS*n-1:0]    d_out,
    output logic [PORTS-1:0]      ld,
    output logic                  err
);

    state_t                 state_q, state_d;
    logic [PORT_ID_W-1:0]   hold_id_q, hold_id_d;
    logic [n-1:0]           hold_data_q, hold_data_d;
    logic [PORTS-1:0]       ld_d;
    logic                   err_d;
    logic                   wr_ack_d;
    logic                   busy_d;
    logic [PORTS-1:0]       wr_onehot;
    logic                   wr_hit;

    // Decode of the captured destination address.
    port_id_decode #(
        .PORTS   (PORTS),
        .BASE_ID (BASE_ID)
    ) u_wr_decode (
        .id       (hold_id_q),
        .onehot_c (wr_onehot),
        .hit_c    (wr_hit)
    );

    // State register, holding registers, status flags and port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_id_q   <= '0;
            hold_data_q <= '0;
            ld          <= '0;
            err         <= 1'b0;
            wr_ack      <= 1'b0;
            busy        <= 1'b0;
            d_out       <= '0;
        end else begin
            state_q     <= state_d;
            hold_id_q   <= hold_id_d;
            hold_data_q <= hold_data_d;
            ld          <= ld_d;
            err         <= err_d;
            wr_ack      <= wr_ack_d;
            busy        <= busy_d;
            for (int unsigned k = 0; k < PORTS; k++) begin
                if (ld_d[k]) begin
                    d_out[k*n +: n] <= hold_data_q;
                end
            end
        end
    end

    // Next-state and next-output logic; X on wr_req falls through as no request.
    always_comb begin
        state_d     = state_q;
        hold_id_d   = hold_id_q;
        hold_data_d = hold_data_q;
        ld_d        = '0;
        err_d       = err;
        case (state_q)
            IDLE: begin
                if (wr_req == 1'b1) begin
                    state_d     = LATCH;
                    hold_id_d   = port_id;
                    hold_data_d = d_in;
                end
            end
            LATCH: begin
                state_d = ACK;
                if (wr_hit) begin
                    ld_d = wr_onehot;
                end else begin
                    err_d = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wr_ack_d = (state_d == ACK);
        busy_d   = (state_d != IDLE);
    end

`ifdef DEMUX_1TN_REG_READBACK_EN
    logic [PORTS-1:0] rb_onehot;
    logic             rb_hit;

    // Decode of the readback address.
    port_id_decode #(
        .PORTS   (PORTS),
        .BASE_ID (BASE_ID)
    ) u_rb_decode (
        .id       (rb_id),
        .onehot_c (rb_onehot),
        .hit_c    (rb_hit)
    );

    // AND-OR mux of the selected port register; zero when unmapped.
    always_comb begin
        rb_data = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            if (rb_hit && rb_onehot[k]) begin
                rb_data = rb_data | d_out[k*n +: n];
            end
        end
    end
`endif

endmodule : demux_1tn_reg

// File: tb/tb_demux_1tn_reg.sv
// Directed self-checking bench for demux_1tn_reg (default and high-BASE_ID builds).
module tb_demux_1tn_reg;

    typedef struct packed {
        logic [7:0] id;
        logic [7:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        wr_req;
    logic [7:0]  port_id;
    logic [7:0]  d_in;
    logic        wr_ack;
    logic        busy;
    logic [31:0] d_out;
    logic [3:0]  ld;
    logic        err;

    logic        b_wr_req;
    logic [7:0]  b_port_id;
    logic [7:0]  b_d_in;
    logic        b_wr_ack;
    logic        b_busy;
    logic [31:0] b_d_out;
    logic [3:0]  b_ld;
    logic        b_err;

`ifdef DEMUX_1TN_REG_READBACK_EN
    logic [7:0]  rb_id;
    logic [7:0]  rb_data;
    logic [7:0]  b_rb_id;
    logic [7:0]  b_rb_data;
`endif

    int          errors;
    int          checks;
    wr_t         sb[$];
    wr_t         e;
    logic [31:0] exp_dout;
    logic        exp_err;

    demux_1tn_reg #(.n(8), .PORTS(4), .BASE_ID(8'h10)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .port_id (port_id),
        .d_in    (d_in),
`ifdef DEMUX_1TN_REG_READBACK_EN
        .rb_id   (rb_id),
        .rb_data (rb_data),
`endif
        .wr_ack  (wr_ack),
        .busy    (busy),
        .d_out   (d_out),
        .ld      (ld),
        .err     (err)
    );

    demux_1tn_reg #(.n(8), .PORTS(4), .BASE_ID(8'hFE)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (b_wr_req),
        .port_id (b_port_id),
        .d_in    (b_d_in),
`ifdef DEMUX_1TN_REG_READBACK_EN
        .rb_id   (b_rb_id),
        .rb_data (b_rb_data),
`endif
        .wr_ack  (b_wr_ack),
        .busy    (b_busy),
        .d_out   (b_d_out),
        .ld      (b_ld),
        .err     (b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full write to the default DUT starting at a falling edge.
    task automatic do_write(input logic [7:0] id, input logic [7:0] data);
        int         off;
        logic [3:0] exp_ld;
        wr_req  = 1'b1;
        port_id = id;
        d_in    = data;
        sb.push_back('{id: id, data: data});
        @(negedge clk);
        wr_req  = 1'b0;
        port_id = 8'($urandom);
        d_in    = 8'($urandom);
        check("latch_busy", 32'(busy), 32'd1);
        check("latch_ack", 32'(wr_ack), 32'd0);
        check("latch_ld", 32'(ld), 32'd0);
        @(negedge clk);
        e      = sb.pop_front();
        off    = int'(e.id) - 16;
        exp_ld = 4'b0000;
        if (off >= 0 && off < 4) begin
            exp_ld[off]         = 1'b1;
            exp_dout[off*8 +: 8] = e.data;
        end else begin
            exp_err = 1'b1;
        end
        check("ack_wr_ack", 32'(wr_ack), 32'd1);
        check("ack_busy", 32'(busy), 32'd1);
        check("ack_ld", 32'(ld), 32'(exp_ld));
        check("ack_dout", d_out, exp_dout);
        check("ack_err", 32'(err), 32'(exp_err));
        @(negedge clk);
        check("idle_wr_ack", 32'(wr_ack), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ld", 32'(ld), 32'd0);
        check("idle_dout", d_out, exp_dout);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        wr_req    = 1'b0;
        port_id   = 8'h00;
        d_in      = 8'h00;
        b_wr_req  = 1'b0;
        b_port_id = 8'h00;
        b_d_in    = 8'h00;
`ifdef DEMUX_1TN_REG_READBACK_EN
        rb_id     = 8'h00;
        b_rb_id   = 8'h00;
`endif
        exp_dout  = 32'h0;
        exp_err   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_dout", d_out, 32'h0);
        check("rst_ld", 32'(ld), 32'd0);
        check("rst_wr_ack", 32'(wr_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // First request on the first edge after reset release, then a second port.
        do_write(8'h12, 8'hA5);
        do_write(8'h10, 8'h5A);

        // Unmapped write sets a sticky error without touching the ports.
        do_write(8'h20, 8'hFF);
        repeat (10) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("err_dout_hold", d_out, exp_dout);

        // Back-to-back requests: only values sampled in IDLE reach port 0.
        wr_req  = 1'b1;
        port_id = 8'h10;
        for (int i = 0; i < 9; i++) begin
            d_in = 8'h40 + 8'(i);
            if (i % 3 == 0) sb.push_back('{id: 8'h10, data: d_in});
            @(negedge clk);
            if (i % 3 == 1) begin
                e = sb.pop_front();
                exp_dout[7:0] = e.data;
                check("b2b_ack", 32'(wr_ack), 32'd1);
                check("b2b_ld", 32'(ld), 32'b0001);
                check("b2b_dout", d_out, exp_dout);
            end else begin
                check("b2b_noack", 32'(wr_ack), 32'd0);
            end
        end
        wr_req = 1'b0;
        @(negedge clk);

        // X on the request line in IDLE is not a request.
        wr_req = 1'bx;
        repeat (2) begin
            @(negedge clk);
            check("x_req_busy", 32'(busy), 32'd0);
        end
        wr_req = 1'b0;

        // Reset asserted during LATCH aborts the write.
        wr_req  = 1'b1;
        port_id = 8'h11;
        d_in    = 8'h99;
        @(negedge clk);
        wr_req = 1'b0;
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_dout = 32'h0;
        exp_err  = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dout", d_out, 32'h0);
        check("abort_ack", 32'(wr_ack), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_ack", 32'(wr_ack), 32'd0);
        check("post_abort_dout", d_out, 32'h0);
        do_write(8'h13, 8'h3C);

`ifdef DEMUX_1TN_REG_READBACK_EN
        // Readback of loaded ports and of an unmapped address.
        do_write(8'h10, 8'h11);
        do_write(8'h11, 8'h22);
        do_write(8'h12, 8'h33);
        do_write(8'h13, 8'h44);
        rb_id = 8'h11;
        #1 check("rb_port1", 32'(rb_data), 32'h22);
        rb_id = 8'h13;
        #1 check("rb_port3", 32'(rb_data), 32'h44);
        rb_id = 8'h09;
        #1 check("rb_unmapped", 32'(rb_data), 32'h0);
        @(negedge clk);
`endif

        // High BASE_ID: 8'hFF maps to port 1, 8'h00 does not wrap into range.
        b_wr_req  = 1'b1;
        b_port_id = 8'hFF;
        b_d_in    = 8'h77;
        @(negedge clk);
        b_wr_req = 1'b0;
        @(negedge clk);
        check("bnd_ack", 32'(b_wr_ack), 32'd1);
        check("bnd_ld", 32'(b_ld), 32'b0010);
        check("bnd_dout", b_d_out, 32'h0000_7700);
        check("bnd_err0", 32'(b_err), 32'd0);
        @(negedge clk);
        b_wr_req  = 1'b1;
        b_port_id = 8'h00;
        b_d_in    = 8'hEE;
        @(negedge clk);
        b_wr_req = 1'b0;
        @(negedge clk);
        check("bnd_wrap_ack", 32'(b_wr_ack), 32'd1);
        check("bnd_wrap_ld", 32'(b_ld), 32'd0);
        check("bnd_wrap_err", 32'(b_err), 32'd1);
        check("bnd_wrap_dout", b_d_out, 32'h0000_7700);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_demux_1tn_reg
